// File: rtl/alu_sequencer_if.sv
// Issue-side bus of the tiny16 ALU sequencer: instruction handshake from
// decode plus the opcode/operand/result pins shared with the ALU.
//
// Handshake: an instruction transfers on a rising clk edge where instr_valid
// and instr_ready are both high. The producer holds instr stable while
// instr_valid is high. instr_ready does not depend on instr_valid.
interface alu_sequencer_if #(
  parameter int WIDTH = 16
);
  logic             instr_valid;
  logic             instr_ready;
  logic [WIDTH-1:0] instr;
  logic [3:0]       alu_opcode;
  logic             alu_ar_flag;
  logic [WIDTH-1:0] alu_src1;
  logic [WIDTH-1:0] alu_src2;
  logic             alu_out_en;
  logic [WIDTH-1:0] alu_out;
  logic [3:0]       alu_flags;

  // Decode + ALU side: supplies instructions and results
  modport master (
    output instr_valid,
    output instr,
    output alu_out,
    output alu_flags,
    input  instr_ready,
    input  alu_opcode,
    input  alu_ar_flag,
    input  alu_src1,
    input  alu_src2,
    input  alu_out_en
  );

  // Sequencer side
  modport slave (
    input  instr_valid,
    input  instr,
    input  alu_out,
    input  alu_flags,
    output instr_ready,
    output alu_opcode,
    output alu_ar_flag,
    output alu_src1,
    output alu_src2,
    output alu_out_en
  );
endinterface

// File: rtl/alu_sequencer.sv
// Issue side of the tiny16 ALU. Accepts one instruction per handshake, reads
// operands from an 8x16 register file (r0 hard-wired to zero), drives the ALU
// pins, waits out the ALU result/output register stages, then writes back the
// result and latches the flags. Illegal opcodes and divide-by-zero pulse err.
module alu_sequencer #(
  parameter int NREGS = 8,
  parameter int WIDTH = 16
) (
  input  logic                     clk,
  input  logic                     rst,
  alu_sequencer_if.slave           bus,
  output logic [3:0]               flags_q,
  output logic                     done,
  output logic                     err,
  input  logic                     dbg_we,
  input  logic [$clog2(NREGS)-1:0] dbg_addr,
  input  logic [WIDTH-1:0]         dbg_wdata,
  output logic [WIDTH-1:0]         dbg_rdata,
  output logic [2:0]               dbg_state
);

  localparam int AW = $clog2(NREGS);

  typedef enum logic [2:0] {
    S_IDLE    = 3'd0,
    S_ISSUE   = 3'd1,
    S_CAPTURE = 3'd2,
    S_WB      = 3'd3,
    S_ERR     = 3'd4
  } state_t;

  localparam logic [3:0] OP_FIRST = 4'b0011;
  localparam logic [3:0] OP_LAST  = 4'b1011;
  localparam logic [3:0] OP_DIV   = 4'b0110;

  state_t           state_q, state_d;
  logic [WIDTH-1:0] regs_q [NREGS];

  logic [3:0]       opcode_q;
  logic             ar_flag_q;
  logic [WIDTH-1:0] src1_q;
  logic [WIDTH-1:0] src2_q;
  logic [AW-1:0]    rd_q;
  logic             done_q;

  // Instruction fields
  logic [3:0]       dec_op;
  logic             dec_ar;
  logic [AW-1:0]    dec_rd;
  logic [AW-1:0]    dec_rs1;
  logic [AW-1:0]    dec_rs2;
  logic [1:0]       instr_unused;

  assign dec_op       = bus.instr[15:12];
  assign dec_ar       = bus.instr[11];
  assign dec_rd       = bus.instr[10:8];
  assign dec_rs1      = bus.instr[7:5];
  assign dec_rs2      = bus.instr[4:2];
  assign instr_unused = bus.instr[1:0];

  // Register file read ports; r0 always reads zero
  logic [WIDTH-1:0] rs1_val;
  logic [WIDTH-1:0] rs2_val;

  assign rs1_val   = (dec_rs1 == '0) ? '0 : regs_q[dec_rs1];
  assign rs2_val   = (dec_rs2 == '0) ? '0 : regs_q[dec_rs2];
  assign dbg_rdata = (dbg_addr == '0) ? '0 : regs_q[dbg_addr];

  // Acceptance and legality of the offered instruction
  logic ready;
  logic out_en;
  logic err_o;
  logic accept;
  logic op_legal;
  logic div_zero;
  logic issue_go;
  logic wb_we;
  logic dbg_wr;

  assign accept   = bus.instr_valid && ready;
  assign op_legal = (dec_op >= OP_FIRST) && (dec_op <= OP_LAST);
  assign div_zero = (dec_op == OP_DIV) && (rs2_val == '0);
  assign issue_go = accept && op_legal && !div_zero;
  assign wb_we    = (state_q == S_WB) && (rd_q != '0);
  assign dbg_wr   = dbg_we && (state_q == S_IDLE) && (dbg_addr != '0);

  // FSM state register
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= S_IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  // FSM next-state logic
  always_comb begin
    state_d = state_q;
    unique case (state_q)
      S_IDLE: begin
        if (accept) begin
          state_d = (op_legal && !div_zero) ? S_ISSUE : S_ERR;
        end
      end
      S_ISSUE:   state_d = S_CAPTURE;
      S_CAPTURE: state_d = S_WB;
      S_WB:      state_d = S_IDLE;
      S_ERR:     state_d = S_IDLE;
      default:   state_d = S_IDLE;
    endcase
  end

  // FSM outputs decoded from the current state
  always_comb begin
    ready  = 1'b0;
    out_en = 1'b0;
    err_o  = 1'b0;
    unique case (state_q)
      S_IDLE:    ready  = 1'b1;
      S_CAPTURE: out_en = 1'b1;
      S_ERR:     err_o  = 1'b1;
      default: ;
    endcase
  end

  // ALU pin registers, destination latch, flags and the done pulse.
  // The alu_* pins hold from issue through writeback because the ALU
  // computes overflow from the sources at the capture edge.
  always_ff @(posedge clk) begin
    if (rst) begin
      opcode_q  <= '0;
      ar_flag_q <= 1'b0;
      src1_q    <= '0;
      src2_q    <= '0;
      rd_q      <= '0;
      flags_q   <= '0;
      done_q    <= 1'b0;
    end else begin
      if (issue_go) begin
        opcode_q  <= dec_op;
        ar_flag_q <= dec_ar;
        src1_q    <= rs1_val;
        src2_q    <= rs2_val;
        rd_q      <= dec_rd;
      end
      if (state_q == S_WB) begin
        flags_q <= bus.alu_flags;
      end
      done_q <= (state_q == S_WB);
    end
  end

  // Register file writes: writeback in WB, debug writes only in IDLE.
  // Operands are read combinationally, so a handshake on the same edge as a
  // debug write sees the pre-write value. r0 is never written.
  always_ff @(posedge clk) begin
    if (rst) begin
      for (int i = 0; i < NREGS; i++) begin
        regs_q[i] <= '0;
      end
    end else if (wb_we) begin
      regs_q[rd_q] <= bus.alu_out;
    end else if (dbg_wr) begin
      regs_q[dbg_addr] <= dbg_wdata;
    end
  end

  assign bus.instr_ready = ready;
  assign bus.alu_out_en  = out_en;
  assign bus.alu_opcode  = opcode_q;
  assign bus.alu_ar_flag = ar_flag_q;
  assign bus.alu_src1    = src1_q;
  assign bus.alu_src2    = src2_q;
  assign done            = done_q;
  assign err             = err_o;
  assign dbg_state       = state_q;

endmodule
